seg_scan_driver: RTL and testbench

- Downstream display stage of the binary-to-BCD converter.
- Latches the packed 8-digit BCD word when the MMIO digit write strobe fires.
- Time-multiplexes the eight digits onto the board's common 7-segment bus using a prescaled scan counter.
- Drives active-low segment and digit-enable pins directly.

---
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 95 +++++++++
 tb/tb_seg_scan_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver_if
// Purpose  : MMIO digit-write bus and 7-segment pin bundle for seg_scan_driver.
// Revision : 1.0  initial release
// ============================================================================
interface seg_scan_driver_if;
   logic        digwrite;
   logic        digcs;
   logic [31:0] bcd_in;
   logic [7:0]  seg_out;
   logic [7:0]  seg_en;

   modport master (
      output digwrite, digcs, bcd_in,
      input  seg_out, seg_en
   );

   modport slave (
      input  digwrite, digcs, bcd_in,
      output seg_out, seg_en
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Latches a packed 8-digit BCD word and scans it onto an active-low
//            common 7-segment bus. Optional macro: LEADING_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
   parameter int SCAN_DIV = 100000,
   parameter int CNT_W    = 17
) (
   input  wire logic         clk,
   input  wire logic         rst,
   seg_scan_driver_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_PRESC_MAX = CNT_W'(SCAN_DIV - 1);

   logic [31:0]      r_disp;
   logic [CNT_W-1:0] r_presc;
   logic [2:0]       r_idx;
   logic [7:0]       r_seg_en;
   logic [7:0]       r_seg_out;

   logic             w_tick;
   logic [2:0]       w_next_idx;
   logic [31:0]      w_shifted;
   logic [3:0]       w_digit;
   logic [6:0]       w_seg;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b0111111;
      endcase
   endfunction

   assign w_tick     = (r_presc == c_PRESC_MAX);
   assign w_next_idx = r_idx + 3'd1;
   // Upper digits shifted down so bits [3:0] hold the digit being lit next.
   assign w_shifted  = r_disp >> {w_next_idx, 2'b00};
   assign w_digit    = w_shifted[3:0];

`ifdef LEADING_ZERO_BLANK_EN
   logic w_blank;
   assign w_blank = (w_next_idx != 3'd0) && (w_shifted == 32'h0);

   always_comb begin
      w_seg = dec(w_digit);
      if (w_blank) begin
         w_seg = 7'h7F;
      end
   end
`else
   always_comb begin
      w_seg = dec(w_digit);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_disp    <= 32'h0;
         r_presc   <= '0;
         r_idx     <= 3'd7;
         r_seg_en  <= 8'hFF;
         r_seg_out <= 8'hFF;
      end else begin
         if (bus.digcs && bus.digwrite) begin
            r_disp <= bus.bcd_in;
         end
         if (w_tick) begin
            r_presc   <= '0;
            r_idx     <= w_next_idx;
            r_seg_en  <= ~(8'b1 << w_next_idx);
            r_seg_out <= {1'b1, w_seg};
         end else begin
            r_presc <= r_presc + CNT_W'(1);
         end
      end
   end

   assign bus.seg_en  = r_seg_en;
   assign bus.seg_out = r_seg_out;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Scoreboard bench for seg_scan_driver with a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_driver;

   localparam int SD = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seg_scan_driver_if bus();

   seg_scan_driver #(
      .SCAN_DIV (SD),
      .CNT_W    (3)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
   };

   logic [15:0] exp_q [$];
   logic [31:0] m_disp;
   logic [7:0]  m_en;
   logic [7:0]  m_out;
   int          n_cyc;

   // Reference: slot s (s>=1) begins SD*s cycles after reset and shows digit (s-1)%8.
   always @(posedge clk) begin
      int d;
      logic [31:0] upper;
      if (rst) begin
         n_cyc  = 0;
         m_disp = 32'h0;
         m_en   = 8'hFF;
         m_out  = 8'hFF;
      end else begin
         n_cyc = n_cyc + 1;
         if (n_cyc % SD == 0) begin
            d     = ((n_cyc / SD) - 1) % 8;
            upper = m_disp >> (4 * d);
            m_en  = ~(8'h01 << d);
            m_out = {1'b1, seg_tab[upper[3:0]]};
`ifdef LEADING_ZERO_BLANK_EN
            if (d != 0 && upper == 32'h0) m_out = 8'hFF;
`endif
         end
         if (bus.digcs && bus.digwrite) m_disp = bus.bcd_in;
      end
      exp_q.push_back({m_en, m_out});
   end

   always @(negedge clk) begin
      logic [15:0] e;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_empty t=%0t actual seg_en=%h seg_out=%h required a queued value", $time, bus.seg_en, bus.seg_out);
      end else begin
         e = exp_q.pop_front();
         if ({bus.seg_en, bus.seg_out} !== e) begin
            errors = errors + 1;
            $display("FAIL scan t=%0t actual seg_en=%h seg_out=%h required seg_en=%h seg_out=%h", $time, bus.seg_en, bus.seg_out, e[15:8], e[7:0]);
         end
      end
   end

   task automatic do_reset(input int cyc);
      @(negedge clk);
      rst = 1'b1;
      repeat (cyc) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_write(input logic cs, input logic wr, input logic [31:0] data);
      bus.digcs    = cs;
      bus.digwrite = wr;
      bus.bcd_in   = data;
      @(negedge clk);
      bus.digcs    = 1'b0;
      bus.digwrite = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.digcs    = 1'b0;
      bus.digwrite = 1'b0;
      bus.bcd_in   = 32'h0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (SD) @(posedge clk);
      #1;
      checks = checks + 1;
      if (bus.seg_en !== 8'hFE || bus.seg_out !== 8'hC0) begin
         errors = errors + 1;
         $display("FAIL first_digit actual seg_en=%h seg_out=%h required FE C0", bus.seg_en, bus.seg_out);
      end

      @(negedge clk);
      do_write(1'b1, 1'b1, 32'h0000_1234);
      repeat (40) @(negedge clk);

      // Write strobe without chip select must be ignored.
      bus.digcs    = 1'b0;
      bus.digwrite = 1'b1;
      bus.bcd_in   = 32'h9999_9999;
      repeat (40) @(negedge clk);
      bus.digwrite = 1'b0;

      do_reset(2);
      do_write(1'b1, 1'b1, 32'h0000_00AF);
      repeat (40) @(negedge clk);

      // Write lands on the edge that lights digit0 for the second time.
      do_reset(2);
      do_write(1'b1, 1'b1, 32'h0000_0007);
      repeat (SD * 9 - 2) @(negedge clk);
      do_write(1'b1, 1'b1, 32'h0000_0005);
      repeat (40) @(negedge clk);

      // Reset while digit 5 is lit.
      do_reset(2);
      do_write(1'b1, 1'b1, 32'h8765_4321);
      repeat (SD * 6 + 1 - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 3000; i++) begin
         bus.digcs    = 1'($urandom % 2);
         bus.digwrite = 1'($urandom % 2);
         bus.bcd_in   = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(0, 8)));
         rst          = ($urandom % 300 == 0);
         @(negedge clk);
      end
      rst          = 1'b0;
      bus.digcs    = 1'b0;
      bus.digwrite = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
